pipe_stage_chain: RTL and testbench

- Parametrised successor to the per-boundary pipeline registers (fetch/decode, decode/ex, ex/mem, mem/wb, PC).
- One block models a chain of DEPTH pipeline registers carrying a DATA_W payload and a CTRL_W control bundle (regwrite, memwrite, branch, etc.).
- Adds what the fixed registers lack: asynchronous reset, a valid bit per stage, a global stall (hold), per-stage flush that inserts a bubble, occupancy tracking and a kill counter.
- Used for every inter-stage boundary and for multi-cycle functional-unit delay lines.

---
 rtl/pipe_stage_chain.sv | 114 +++++++++++
 tb/tb_pipe_stage_chain.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : DEPTH-stage pipeline register chain with valid bits, global stall,
//            per-stage flush (bubble insertion), occupancy and kill counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  kill_count
);

    localparam int            KW         = CNT_W + OCC_W;
    localparam logic [KW-1:0] C_KILL_MAX = KW'({CNT_W{1'b1}});

    logic [DEPTH-1:0]  r_valid;
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [OCC_W-1:0]  r_occ;
    logic [CNT_W-1:0]  r_kill;

    logic [DEPTH-1:0]  w_cand_valid;
    logic [DEPTH-1:0]  w_nxt_valid;
    logic [CTRL_W-1:0] w_nxt_ctrl [DEPTH];
    logic [DATA_W-1:0] w_nxt_data [DEPTH];
    logic [OCC_W-1:0]  w_occ_nxt;
    logic [OCC_W-1:0]  w_kill_inc;
    logic [KW-1:0]     w_kill_sum;
    logic [CNT_W-1:0]  w_kill_nxt;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic              w_src_valid;
        logic [CTRL_W-1:0] w_src_ctrl;
        logic [DATA_W-1:0] w_src_data;
        logic [CTRL_W-1:0] w_cand_ctrl;
        logic [DATA_W-1:0] w_cand_data;

        if (gi == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_ctrl  = in_valid ? in_ctrl : '0;
            assign w_src_data  = in_data;
        end else begin : g_body
            assign w_src_valid = r_valid[gi-1];
            assign w_src_ctrl  = r_ctrl[gi-1];
            assign w_src_data  = r_data[gi-1];
        end

        assign w_cand_valid[gi] = stall ? r_valid[gi] : w_src_valid;
        assign w_cand_ctrl      = stall ? r_ctrl[gi]  : w_src_ctrl;
        assign w_cand_data      = stall ? r_data[gi]  : w_src_data;

        // Flush wins over stall: the held or advancing entry becomes a bubble.
        assign w_nxt_valid[gi] = w_cand_valid[gi] & ~flush[gi];
        assign w_nxt_ctrl[gi]  = flush[gi] ? '0 : w_cand_ctrl;
        assign w_nxt_data[gi]  = w_cand_data;
    end

    always_comb begin
        w_occ_nxt  = '0;
        w_kill_inc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt  = w_occ_nxt  + OCC_W'(w_nxt_valid[i]);
            w_kill_inc = w_kill_inc + OCC_W'(w_cand_valid[i] & flush[i]);
        end
        w_kill_sum = KW'(r_kill) + KW'(w_kill_inc);
        w_kill_nxt = (w_kill_sum > C_KILL_MAX) ? {CNT_W{1'b1}} : w_kill_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_occ   <= '0;
            r_kill  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid <= w_nxt_valid;
            r_occ   <= w_occ_nxt;
            r_kill  <= w_kill_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                r_ctrl[i] <= w_nxt_ctrl[i];
                r_data[i] <= w_nxt_data[i];
            end
        end
    end

    assign out_valid   = r_valid[DEPTH-1];
    assign out_ctrl    = r_ctrl[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign stage_valid = r_valid;
    assign occupancy   = r_occ;
    assign kill_count  = r_kill;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_chain
// Brief    : Directed self-checking bench for pipe_stage_chain (DEPTH=3, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 16;
    localparam int DEPTH  = 3;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              reset;
    logic              stall;
    logic [DEPTH-1:0]  flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [DEPTH-1:0]  stage_valid;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  kill_count;

    int checks = 0;
    int errors = 0;

    pipe_stage_chain #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .stage_valid(stage_valid),
        .occupancy  (occupancy),
        .kill_count (kill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = '0;
        present(1'b0, '0, '0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_ctrl", 32'(out_ctrl), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_kill", 32'(kill_count), 0);
        chk("rst_stage_valid", 32'(stage_valid), 0);
        reset = 1'b0;

        // Fill: A, B, C
        present(1'b1, 16'h1111, 8'h0A); tick();
        chk("fill1_occ", 32'(occupancy), 1);
        chk("fill1_out_valid", 32'(out_valid), 0);
        present(1'b1, 16'h2222, 8'h0B); tick();
        chk("fill2_occ", 32'(occupancy), 2);
        present(1'b1, 16'h3333, 8'h0C); tick();
        chk("fill3_out_valid", 32'(out_valid), 1);
        chk("fill3_out_data", 32'(out_data), 32'h0A);
        chk("fill3_out_ctrl", 32'(out_ctrl), 32'h1111);
        chk("fill3_occ", 32'(occupancy), 3);

        // Stall 4 cycles; stage 0 must ignore the presented entry
        stall = 1'b1;
        present(1'b1, 16'h4444, 8'h0D);
        repeat (4) tick();
        chk("stall_out_data", 32'(out_data), 32'h0A);
        chk("stall_out_valid", 32'(out_valid), 1);
        chk("stall_occ", 32'(occupancy), 3);
        chk("stall_stage_valid", 32'(stage_valid), 32'h7);

        // Flush stage 1 while stalled
        flush = 3'b010; tick();
        chk("flush1_stage_valid", 32'(stage_valid), 32'h5);
        chk("flush1_occ", 32'(occupancy), 2);
        chk("flush1_kill", 32'(kill_count), 1);
        chk("flush1_out_data", 32'(out_data), 32'h0A);

        // Release: bubble reaches output, then C
        flush = '0; stall = 1'b0;
        present(1'b0, '0, 8'h00); tick();
        chk("bubble_out_valid", 32'(out_valid), 0);
        chk("bubble_out_ctrl", 32'(out_ctrl), 0);
        chk("bubble_occ", 32'(occupancy), 1);
        chk("bubble_stage_valid", 32'(stage_valid), 32'h2);
        tick();
        chk("drainC_out_valid", 32'(out_valid), 1);
        chk("drainC_out_data", 32'(out_data), 32'h0C);
        chk("drainC_out_ctrl", 32'(out_ctrl), 32'h3333);
        tick();
        chk("empty_occ", 32'(occupancy), 0);

        // Invalid entry with ctrl set: ctrl forced to zero, not a kill
        present(1'b0, 16'hFFFF, 8'h55); tick();
        chk("inv_stage_valid", 32'(stage_valid), 0);
        chk("inv_kill", 32'(kill_count), 1);
        present(1'b0, 16'h0000, 8'h00); tick(); tick();
        chk("inv_out_valid", 32'(out_valid), 0);
        chk("inv_out_ctrl", 32'(out_ctrl), 0);
        chk("inv_out_data", 32'(out_data), 32'h55);

        // Repeated stage-0 kills saturate the 2-bit counter at 3
        present(1'b1, 16'hAAAA, 8'h11);
        flush = 3'b001; tick();
        chk("sat1_kill", 32'(kill_count), 2);
        chk("sat1_stage_valid", 32'(stage_valid), 0);
        tick();
        chk("sat2_kill", 32'(kill_count), 3);
        repeat (3) tick();
        chk("sat5_kill", 32'(kill_count), 3);
        flush = '0;

        // Fill, stall, then async reset mid-cycle
        present(1'b1, 16'h0001, 8'h01); tick();
        present(1'b1, 16'h0002, 8'h02); tick();
        present(1'b1, 16'h0003, 8'h03); tick();
        chk("refill_occ", 32'(occupancy), 3);
        stall = 1'b1; tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_ctrl", 32'(out_ctrl), 0);
        chk("arst_occ", 32'(occupancy), 0);
        chk("arst_kill", 32'(kill_count), 0);
        stall = 1'b0;
        present(1'b1, 16'h0F0F, 8'h77);
        #2 reset = 1'b0;
        tick();
        chk("lat1_out_valid", 32'(out_valid), 0);
        present(1'b0, '0, '0); tick();
        chk("lat2_out_valid", 32'(out_valid), 0);
        tick();
        chk("lat3_out_valid", 32'(out_valid), 1);
        chk("lat3_out_data", 32'(out_data), 32'h77);
        chk("lat3_out_ctrl", 32'(out_ctrl), 32'h0F0F);

        // Occupancy-2 chain, stall + flush all: adds 2 kills
        present(1'b1, 16'h0008, 8'h88); tick();
        chk("occ_a", 32'(occupancy), 1);
        present(1'b1, 16'h0009, 8'h99); tick();
        chk("occ_b", 32'(occupancy), 2);
        stall = 1'b1; flush = 3'b111; tick();
        chk("flushall_kill", 32'(kill_count), 2);
        chk("flushall_occ", 32'(occupancy), 0);
        chk("flushall_stage_valid", 32'(stage_valid), 0);
        stall = 1'b0; flush = '0;
        present(1'b1, 16'h000A, 8'hAA); tick();
        present(1'b1, 16'h000B, 8'hBB); tick();
        chk("occ_c", 32'(occupancy), 2);
        stall = 1'b1; flush = 3'b111; tick();
        chk("flushall_sat_kill", 32'(kill_count), 3);
        chk("flushall_sat_occ", 32'(occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
